// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command constants and state/grant encodings for the SDRAM arbiter
//
// Purpose : SDRAM command words {cs_n,ras_n,cas_n,we_n}, FSM state encoding,
//           and arbitration winner encoding used by sdram_arbit and sdram_arbit_pri.
// Ports   : none (package).
// Config  : ARBIT_RR_EN is consumed by the modules, not by this package.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_AREF = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } grant_t;

endpackage

// File: rtl/sdram_arbit_pri.sv
// rtl/sdram_arbit_pri.sv - combinational winner selection among refresh, write and read requests
//
// Purpose : Refresh always wins. Write beats read under fixed priority; with
//           ARBIT_RR_EN defined a write/read tie goes to whichever did not win last.
// Ports   : aref_req, wr_req, rd_req  in   request levels
//           last_rd                   in   (ARBIT_RR_EN only) 1 = last wr/rd grant was read
//           winner                    out  grant_t selection, GNT_NONE when idle
// Config  : ARBIT_RR_EN enables the round-robin tie break.
module sdram_arbit_pri
  import sdram_pkg::*;
(
  input  logic   aref_req,
  input  logic   wr_req,
  input  logic   rd_req,
`ifdef ARBIT_RR_EN
  input  logic   last_rd,
`endif
  output grant_t winner
);

  always_comb begin
    winner = GNT_NONE;
    if (aref_req) begin
      winner = GNT_AREF;
    end else if (wr_req && rd_req) begin
`ifdef ARBIT_RR_EN
      // Tie: the requester that did not win last time goes first.
      winner = last_rd ? GNT_WR : GNT_RD;
`else
      winner = GNT_WR;
`endif
    end else if (wr_req) begin
      winner = GNT_WR;
    end else if (rd_req) begin
      winner = GNT_RD;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command bus arbiter between init, refresh, write and read requesters
//
// Purpose : IDLE waits for init_done, then ARBIT grants one requester at a time.
//           A granted requester owns the command bus until its *_end pulse,
//           after which the FSM always passes back through ARBIT.
// Ports   : sclk, rst_n (async, active-low)
//           init_done, init_cmd, init_addr           init sequencer
//           aref_req, aref_end, aref_cmd, aref_addr  refresh requester
//           wr_req, wr_end, wr_cmd, wr_addr          write requester
//           rd_req, rd_end, rd_cmd, rd_addr          read requester
//           aref_en, wr_en, rd_en                    registered one-cycle grants
//           sdram_cmd, sdram_addr, sdram_cke         muxed SDRAM command bus
// Config  : ARBIT_RR_EN - alternate write/read on ties via a last-grant flag.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int ADDR_W = 12
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [CMD_W-1:0]  sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_cke
);

  state_t r_state;
  logic   r_aref_en;
  logic   r_wr_en;
  logic   r_rd_en;
  grant_t w_winner;

`ifdef ARBIT_RR_EN
  // Resets to "read" so the first write/read tie goes to write.
  logic   r_last_rd;
`endif

  sdram_arbit_pri u_pri (
    .aref_req (aref_req),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
`ifdef ARBIT_RR_EN
    .last_rd  (r_last_rd),
`endif
    .winner   (w_winner)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
`ifdef ARBIT_RR_EN
      r_last_rd <= 1'b1;
`endif
    end else begin
      // Grants are pulses: only the ARBIT exit cycle sets one.
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (init_done) r_state <= S_ARBIT;
        end
        S_ARBIT: begin
          case (w_winner)
            GNT_AREF: begin
              r_state   <= S_AREF;
              r_aref_en <= 1'b1;
            end
            GNT_WR: begin
              r_state   <= S_WRITE;
              r_wr_en   <= 1'b1;
`ifdef ARBIT_RR_EN
              r_last_rd <= 1'b0;
`endif
            end
            GNT_RD: begin
              r_state   <= S_READ;
              r_rd_en   <= 1'b1;
`ifdef ARBIT_RR_EN
              r_last_rd <= 1'b1;
`endif
            end
            default: r_state <= S_ARBIT;
          endcase
        end
        S_AREF:  if (aref_end) r_state <= S_ARBIT;
        S_WRITE: if (wr_end)   r_state <= S_ARBIT;
        S_READ:  if (rd_end)   r_state <= S_ARBIT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational bus mux; reset forces IDLE so the init sequencer drives the bus.
  always_comb begin
    sdram_cmd  = CMD_W'(CMD_NOP);
    sdram_addr = '0;
    case (r_state)
      S_IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_W'(CMD_NOP);
        sdram_addr = '0;
      end
    endcase
  end

  assign aref_en   = r_aref_en;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_done = 1'b0;
  logic [3:0]  init_cmd = 4'b1000;
  logic [11:0] init_addr = 12'h111;
  logic        aref_req = 1'b0;
  logic        aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0010;
  logic [11:0] aref_addr = 12'h222;
  logic        wr_req = 1'b0;
  logic        wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [11:0] wr_addr = 12'h333;
  logic        rd_req = 1'b0;
  logic        rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [11:0] rd_addr = 12'h444;
  logic        aref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic        sdram_cke;

  int total = 0;
  int bad = 0;

  // Distinct per-source addresses identify the state: IDLE 111, AREF 222,
  // WRITE 333, READ 444, ARBIT 000.
  localparam logic [11:0] A_IDLE = 12'h111;
  localparam logic [11:0] A_AREF = 12'h222;
  localparam logic [11:0] A_WR   = 12'h333;
  localparam logic [11:0] A_RD   = 12'h444;
  localparam logic [11:0] A_ARB  = 12'h000;

  sdram_arbit #(.CMD_W(4), .ADDR_W(12)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .aref_req   (aref_req),
    .aref_end   (aref_end),
    .aref_cmd   (aref_cmd),
    .aref_addr  (aref_addr),
    .wr_req     (wr_req),
    .wr_end     (wr_end),
    .wr_cmd     (wr_cmd),
    .wr_addr    (wr_addr),
    .rd_req     (rd_req),
    .rd_end     (rd_end),
    .rd_cmd     (rd_cmd),
    .rd_addr    (rd_addr),
    .aref_en    (aref_en),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_cke  (sdram_cke)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  logic [2:0]  exp_g2_en;
  logic [11:0] exp_g2_addr;

  initial begin
`ifdef ARBIT_RR_EN
    exp_g2_en   = 3'b001;
    exp_g2_addr = A_RD;
`else
    exp_g2_en   = 3'b010;
    exp_g2_addr = A_WR;
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", 32'(sdram_addr), 32'(A_IDLE));
    chk("rst_cmd", 32'(sdram_cmd), 32'(4'b1000));
    chk("rst_cke", 32'(sdram_cke), 32'(1'b1));
    chk("rst_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    tick();
    tick();
    rst_n = 1'b1;

    // Stay in IDLE until init_done
    for (int i = 0; i < 8; i++) tick();
    chk("idle_hold", 32'(sdram_addr), 32'(A_IDLE));
    init_done = 1'b1;
    tick();
    chk("arbit_cmd", 32'(sdram_cmd), 32'(4'b0111));
    chk("arbit_addr", 32'(sdram_addr), 32'(A_ARB));
    chk("arbit_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));

    // All three request: refresh first
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("aref_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b100));
    chk("aref_pre", 32'(sdram_cmd), 32'(4'b0010));
    chk("aref_addr", 32'(sdram_addr), 32'(A_AREF));
    aref_cmd = 4'b0001;
    tick();
    chk("aref_pulse", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    chk("aref_ref", 32'(sdram_cmd), 32'(4'b0001));
    aref_end = 1'b1; aref_req = 1'b0;
    tick();
    aref_end = 1'b0;
    chk("aref_back", 32'(sdram_addr), 32'(A_ARB));
    chk("aref_back_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    tick();
    chk("g1_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b010));
    chk("g1_addr", 32'(sdram_addr), 32'(A_WR));

    // Foreign end ignored in WRITE
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    chk("wr_ign_rdend", 32'(sdram_addr), 32'(A_WR));
    chk("wr_ign_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("wr_end_arb", 32'(sdram_addr), 32'(A_ARB));

    // Second tie grant: rd under round robin, wr otherwise
    tick();
    chk("g2_en", 32'({aref_en, wr_en, rd_en}), 32'(exp_g2_en));
    chk("g2_addr", 32'(sdram_addr), 32'(exp_g2_addr));
    if (exp_g2_en[0]) rd_end = 1'b1;
    else wr_end = 1'b1;
    tick();
    rd_end = 1'b0; wr_end = 1'b0;
    chk("g2_end_arb", 32'(sdram_addr), 32'(A_ARB));
    tick();
    chk("g3_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b010));
    chk("g3_addr", 32'(sdram_addr), 32'(A_WR));

    // End coinciding with refresh request: ARBIT first, then refresh
    wr_end = 1'b1; aref_req = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("endreq_arb", 32'(sdram_addr), 32'(A_ARB));
    chk("endreq_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    tick();
    chk("endreq_aref", 32'({aref_en, wr_en, rd_en}), 32'(3'b100));
    aref_end = 1'b1; aref_req = 1'b0;
    tick();
    aref_end = 1'b0; wr_req = 1'b0;
    chk("aref2_back", 32'(sdram_addr), 32'(A_ARB));
    tick();
    chk("rd_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b001));
    chk("rd_addr", 32'(sdram_addr), 32'(A_RD));

    // Asynchronous reset during READ
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
    chk("rst_mid_addr", 32'(sdram_addr), 32'(A_IDLE));
    init_done = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noinit_en", 32'({aref_en, wr_en, rd_en}), 32'(3'b000));
      chk("noinit_addr", 32'(sdram_addr), 32'(A_IDLE));
    end
    init_done = 1'b1;
    tick();
    chk("reinit_arb", 32'(sdram_addr), 32'(A_ARB));
    tick();
    chk("reinit_rd", 32'({aref_en, wr_en, rd_en}), 32'(3'b001));
    chk("cke_run", 32'(sdram_cke), 32'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
